// File: rtl/modexp_datapath.sv
// Operand capture and multiply/reduce datapath for base^exp mod modulus,
// stepped by an external controller through initialize/en_multiply/en_modulo/done.
module modexp_datapath #(
  parameter int W = 16,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_base,
  input  logic [E-1:0] in_exp,
  input  logic [W-1:0] in_modulus,
  output logic         input_data_ready,
  input  logic         initialize,
  input  logic         en_multiply,
  input  logic         en_modulo,
  input  logic         done,
  output logic         is_multiplication_done,
  output logic [W-1:0] result,
  output logic         result_valid,
  input  logic         result_ack,
  output logic         mod_zero_err
);

  typedef enum logic [1:0] {IDLE, LOADED, RUN, HOLD} state_t;

  state_t         state, next_state;
  logic [W-1:0]   base_r, mod_r, acc_r;
  logic [E-1:0]   exp_r, count_r;
  logic [2*W-1:0] prod_r;
  logic           pending_r;

  logic           run_mul_done;
  logic           mod_step, mul_step;
  logic [2*W-1:0] mul_full;
  logic [W-1:0]   mod_low;

  assign run_mul_done = (count_r == '0) && !pending_r;
  assign mul_full     = (2*W)'(acc_r) * (2*W)'(base_r);
  assign mod_low      = W'(prod_r % (2*W)'(mod_r));

  // A modulo in the same cycle clears pending first, so the multiply is
  // still accepted but consumes the pre-reduction accumulator.
  assign mod_step = en_modulo && pending_r;
  assign mul_step = en_multiply && (count_r != '0) && (!pending_r || mod_step);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && (in_modulus != '0)) next_state = LOADED;
      LOADED:  if (initialize) next_state = RUN;
      RUN:     if (done && run_mul_done) next_state = HOLD;
      HOLD:    if (result_ack && result_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready               = (state == IDLE);
    input_data_ready       = (state == LOADED);
    is_multiplication_done = (state == RUN) ? run_mul_done : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_r       <= '0;
      exp_r        <= '0;
      mod_r        <= '0;
      acc_r        <= '0;
      prod_r       <= '0;
      count_r      <= '0;
      pending_r    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      mod_zero_err <= 1'b0;
    end else begin
      mod_zero_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_modulus != '0) begin
              base_r <= in_base;
              exp_r  <= in_exp;
              mod_r  <= in_modulus;
            end else begin
              mod_zero_err <= 1'b1;
            end
          end
        end
        LOADED: begin
          if (initialize) begin
            acc_r     <= (mod_r == W'(1)) ? '0 : W'(1);
            count_r   <= exp_r;
            prod_r    <= '0;
            pending_r <= 1'b0;
          end
        end
        RUN: begin
          if (mod_step) begin
            acc_r     <= mod_low;
            pending_r <= 1'b0;
          end
          if (mul_step) begin
            prod_r    <= mul_full;
            count_r   <= count_r - E'(1);
            pending_r <= 1'b1;
          end
          if (done && run_mul_done) begin
            result       <= acc_r;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ack && result_valid) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_datapath.sv
// Bench for modexp_datapath: a controller model drives jobs, a scoreboard queue
// holds reference results and a negedge monitor compares each published result.
module tb_modexp_datapath;
  localparam int W = 16;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_base = '0;
  logic [E-1:0] in_exp = '0;
  logic [W-1:0] in_modulus = '0;
  logic         input_data_ready;
  logic         initialize = 1'b0;
  logic         en_multiply = 1'b0;
  logic         en_modulo = 1'b0;
  logic         done = 1'b0;
  logic         is_multiplication_done;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ack = 1'b0;
  logic         mod_zero_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic prev_rv = 1'b0;

  modexp_datapath #(.W(W), .E(E)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_exp(in_exp), .in_modulus(in_modulus),
    .input_data_ready(input_data_ready),
    .initialize(initialize), .en_multiply(en_multiply),
    .en_modulo(en_modulo), .done(done),
    .is_multiplication_done(is_multiplication_done),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .mod_zero_err(mod_zero_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_modexp(input longint b, input int e, input longint m);
    longint r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return W'(r);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int which, input string name);
    logic s;
    for (int n = 0; n < 200; n++) begin
      case (which)
        0:       s = in_ready;
        1:       s = input_data_ready;
        default: s = result_valid;
      endcase
      if (s) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s: got 0 expected 1", name);
  endtask

  // Scoreboard monitor: every rising result_valid must match the oldest expected job.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && result_valid && !prev_rv) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", result, exp_q.pop_front());
      end
      prev_rv = result_valid && !reset;
      if (en_multiply && en_modulo) begin
        errors++;
        $display("FAIL protocol: en_multiply and en_modulo together got 1 expected 0");
      end
    end
  end

  task automatic load(input logic [W-1:0] b, input logic [E-1:0] e,
                      input logic [W-1:0] m, input bit push);
    wait_sig(0, "in_ready");
    in_base = b; in_exp = e; in_modulus = m; in_valid = 1'b1;
    if (push && m != 0) exp_q.push_back(ref_modexp(longint'(b), int'(e), longint'(m)));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_ctrl(input int e, input logic [W-1:0] expv,
                          input int ack_delay, input bit press_in);
    int muls = 0;
    wait_sig(1, "input_data_ready");
    initialize = 1'b1; tick(); initialize = 1'b0;
    while (!is_multiplication_done && muls < 300) begin
      en_multiply = 1'b1; tick(); en_multiply = 1'b0;
      muls++;
      en_modulo = 1'b1; tick(); en_modulo = 1'b0;
    end
    check("multiply_count", muls, e);
    done = 1'b1; tick(); done = 1'b0;
    check("valid_after_done", result_valid, 1);
    for (int i = 0; i < ack_delay; i++) begin
      if (press_in) begin
        in_valid = 1'b1; in_base = 16'h1234; in_exp = 8'd3; in_modulus = 16'd99;
      end
      en_multiply = (i % 2 == 0);
      done = (i % 2 == 1);
      initialize = (i == 3);
      tick();
      en_multiply = 1'b0; done = 1'b0; initialize = 1'b0;
      check("hold_result", result, expv);
      check("hold_valid", result_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_idr", input_data_ready, 0);
    end
    in_valid = 1'b0;
    wait_sig(2, "result_valid");
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("valid_after_ack", result_valid, 0);
    check("in_ready_after_ack", in_ready, 1);
  endtask

  task automatic job(input logic [W-1:0] b, input logic [E-1:0] e,
                     input logic [W-1:0] m, input logic [W-1:0] expv,
                     input int ack_delay, input bit press_in);
    load(b, e, m, 1'b1);
    run_ctrl(int'(e), expv, ack_delay, press_in);
  endtask

  initial begin
    logic [W-1:0] rb, rm;
    logic [E-1:0] re;

    tick(); tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_idr", input_data_ready, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_err", mod_zero_err, 0);
    check("rst_muldone", is_multiplication_done, 1);
    reset = 1'b0;
    tick();

    job(16'd3, 8'd4, 16'd7, 16'd4, 2, 1'b0);
    job(16'd5, 8'd0, 16'd13, 16'd1, 0, 1'b0);
    job(16'd5, 8'd0, 16'd1, 16'd0, 0, 1'b0);
    job(16'hFFFF, 8'd2, 16'hFFFB, 16'h0010, 1, 1'b0);

    // Zero modulus is rejected with a single-cycle error pulse.
    in_base = 16'd9; in_exp = 8'd2; in_modulus = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zero_mod_err", mod_zero_err, 1);
    check("zero_mod_in_ready", in_ready, 1);
    check("zero_mod_idr", input_data_ready, 0);
    tick();
    check("zero_mod_err_clear", mod_zero_err, 0);
    check("zero_mod_idr2", input_data_ready, 0);

    job(16'd3, 8'd4, 16'd7, 16'd4, 10, 1'b1);
    job(16'd2, 8'd5, 16'd11, 16'd10, 0, 1'b0);

    // Abort mid-run; the interrupted job must never publish.
    load(16'd3, 8'd4, 16'd7, 1'b0);
    wait_sig(1, "input_data_ready");
    initialize = 1'b1; tick(); initialize = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en_multiply = 1'b1; tick(); en_multiply = 1'b0;
      en_modulo = 1'b1; tick(); en_modulo = 1'b0;
    end
    check("mid_run_busy", is_multiplication_done, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_valid", result_valid, 0);
    check("abort_idr", input_data_ready, 0);
    check("abort_result", result, 0);
    for (int i = 0; i < 6; i++) begin
      done = 1'b1; en_multiply = (i % 2 == 0); initialize = (i == 2);
      tick();
      done = 1'b0; en_multiply = 1'b0; initialize = 1'b0;
      check("abort_no_result", result_valid, 0);
    end

    for (int k = 0; k < 15; k++) begin
      rb = W'($urandom);
      re = E'($urandom_range(0, 10));
      rm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
      if (rm == 0) rm = 16'd1;
      job(rb, re, rm, ref_modexp(longint'(rb), int'(re), longint'(rm)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_datapath.md
Name: modexp_datapath

Overview:
Operand-capture and arithmetic datapath for modular exponentiation, sitting directly downstream of the FSM controller. It consumes the controller strobes (initialize, en_multiply, en_modulo, done) and returns input_data_ready and is_multiplication_done to it. It computes base^exp mod modulus by repeated multiply-then-reduce steps. Operands arrive on a valid/ready input; the result leaves on a valid/ack output.

Parameters:
W, 16, width of base, modulus and result
E, 8, width of exponent

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
in_valid  input  1  operand set presented
in_ready  output  1  datapath accepts operands this cycle
in_base  input  W  base operand
in_exp  input  E  exponent operand
in_modulus  input  W  modulus operand; must be non-zero
input_data_ready  output  1  to controller: operands loaded, awaiting initialize
initialize  input  1  from controller: load working registers
en_multiply  input  1  from controller: one multiply step
en_modulo  input  1  from controller: one reduction step
done  input  1  from controller: publish result
is_multiplication_done  output  1  to controller: no multiply steps remain
result  output  W  final value, stable while result_valid
result_valid  output  1  result available
result_ack  input  1  consumer takes result
mod_zero_err  output  1  one-cycle pulse: operand set rejected, modulus == 0

Behaviour:
- Internal registers: base_r[W], exp_r[E], mod_r[W], acc_r[W], prod_r[2W], count_r[E], pending_r, and state in {IDLE, LOADED, RUN, HOLD}.
- Reset: state IDLE; all registers 0; result 0; result_valid 0; mod_zero_err 0. Reset has priority over every other input. Reset mid-RUN or mid-HOLD aborts and drops the result.
- Combinational outputs:
  - in_ready = (state == IDLE).
  - input_data_ready = (state == LOADED).
  - is_multiplication_done = 1 in IDLE, LOADED and HOLD. In RUN it is (count_r == 0) && !pending_r.
  - Holding it high outside RUN keeps the controller cycling through DONE and INITIALIZE, so the next initialize pulse starts a newly loaded job.
- IDLE:
  - in_valid with in_modulus != 0: capture all three operands, go to LOADED.
  - in_valid with in_modulus == 0: capture nothing, pulse mod_zero_err for exactly one cycle, stay in IDLE.
- LOADED, on initialize:
  - acc_r <= (mod_r == 1) ? 0 : 1.
  - count_r <= exp_r; prod_r <= 0; pending_r <= 0.
  - Go to RUN.
- initialize in any state other than LOADED is ignored.
- RUN:
  - en_multiply with count_r != 0 and !pending_r: prod_r <= acc_r * base_r at full 2W width; count_r decrements; pending_r <= 1. Otherwise en_multiply is ignored.
  - en_modulo with pending_r: acc_r <= prod_r % mod_r, truncated to W bits; pending_r <= 0. Otherwise en_modulo is ignored.
  - done with is_multiplication_done high: result <= acc_r; result_valid <= 1; go to HOLD. done at any other time is ignored.
- en_multiply and en_modulo asserted in the same cycle: the modulo is applied first, using the old prod_r. The multiply then uses the old acc_r, so results are corrupted. The controller never does this; the bench flags it as a protocol error.
- HOLD:
  - result and result_valid stay stable; all controller strobes are ignored.
  - result_ack with result_valid: result_valid <= 0, go to IDLE, in_ready rises the next cycle.
- Latency from initialize to done: 2*exp + 1 controller cycles (one per multiply, one per modulo, plus the final done).
- exp == 0: is_multiplication_done is high on the first RUN cycle, and result = 1 mod modulus.
- base_r is not reduced before the first multiply. This is safe because the prod_r width covers (2^W - 1)^2.

Test Plan:
- Basic run: base=3, exp=4, mod=7, driven by the controller → exactly 4 multiply/modulo pairs, then result=4, result_valid=1; in_ready=0 until result_ack.
- Exponent zero: base=5, exp=0, mod=13 → result=1 with no en_multiply accepted. Repeat with mod=1 → result=0.
- Zero modulus: in_valid with mod=0 → mod_zero_err high for exactly one cycle, in_ready stays 1, input_data_ready stays 0, no state change.
- Full width: base=0xFFFF, exp=2, mod=0xFFFB → result=16 (0x0010), checking that no intermediate product is truncated.
- Back-pressure: result_ack held low for 10 cycles after result_valid while the controller keeps pulsing → result stable, a second in_valid is not accepted. Then ack, load base=2, exp=5, mod=11 → result=10.
- Reset mid-run: assert reset after 2 multiply steps of base=3, exp=4, mod=7 → next cycle state IDLE, result_valid=0, in_ready=1, and no stale result appears afterwards.
